// File: rtl/reg_dump_tx.sv
// reg_dump_tx
// Debug register-dump transmitter for the single-cycle CPU top (sccomp).
// On a start request it walks reg_sel through registers 0..NREG-1, samples
// reg_data once per register, and sends each value over a UART TX line as
// eight uppercase hex ASCII characters followed by a newline (8N1, LSB first).
//
// Parameters:
//   CLK_DIV  clock cycles per UART bit (>= 2)
//   NREG     number of registers dumped, starting at index 0 (1..32)
// Ports:
//   clk       in   system clock (same clock as sccomp)
//   rst       in   asynchronous active-high reset
//   start     in   dump request, level-sensitive, only looked at while idle
//   reg_sel   out  register index driven to sccomp.reg_sel (registered)
//   reg_data  in   register value returned by sccomp.reg_data
//   tx        out  UART serial output, idles high
//   busy      out  high while a dump is in progress
//   done      out  one-cycle pulse after the final stop bit of the dump

module reg_dump_tx #(
    parameter int CLK_DIV = 868,
    parameter int NREG    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [4:0]        SEL_LAST  = 5'(NREG - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        SEND
    } state_t;

    state_t            state;
    logic [31:0]       hold;
    logic [3:0]        byte_cnt;
    logic [3:0]        bit_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        nibble;
    logic [7:0]        cur_byte;

    // The hold register is shifted left by one nibble after each hex
    // character, so the character in flight always comes from its top nibble.
    // The ninth byte of every register is the newline.
    always_comb begin
        nibble   = hold[31:28];
        cur_byte = 8'h0A;
        if (byte_cnt != 4'd8) begin
            if (nibble <= 4'd9) begin
                cur_byte = 8'h30 + {4'h0, nibble};
            end else begin
                cur_byte = 8'h37 + {4'h0, nibble};
            end
        end
    end

    // Dump sequencer and UART shifter in one machine. bit_idx 0 is the start
    // bit, 1..8 are data bits d0..d7 and 9 is the stop bit. Each tx value is
    // registered on the edge that ends the previous bit. The end of the stop
    // bit doubles as the byte/register advance step, so consecutive bytes
    // follow each other with no idle gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            byte_cnt <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            reg_sel  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        reg_sel <= '0;
                        busy    <= 1'b1;
                        state   <= SEL;
                    end
                end

                SEL: begin
                    hold     <= reg_data;
                    byte_cnt <= '0;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= SEND;
                end

                SEND: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx < 4'd8) begin
                            tx      <= cur_byte[bit_idx[2:0]];
                            bit_idx <= bit_idx + 1'b1;
                        end else if (bit_idx == 4'd8) begin
                            tx      <= 1'b1;
                            bit_idx <= 4'd9;
                        end else begin
                            bit_idx <= '0;
                            if (byte_cnt < 4'd8) begin
                                byte_cnt <= byte_cnt + 1'b1;
                                hold     <= {hold[27:0], 4'h0};
                                tx       <= 1'b0;
                            end else if (reg_sel < SEL_LAST) begin
                                reg_sel <= reg_sel + 1'b1;
                                state   <= SEL;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx
// Directed bench for reg_dump_tx. Two instances share one clock:
// inst 0 dumps a single register, inst 1 dumps all 32 registers.
// Both run with CLK_DIV=4. A negedge monitor decodes each tx line into
// bytes and counts done pulses.

module tb_reg_dump_tx;

    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst_one = 1'b0;
    logic        rst_full = 1'b0;
    logic        start_one = 1'b0;
    logic        start_full = 1'b0;
    logic [31:0] data_one = 32'h0;
    logic [31:0] data_full;
    logic [4:0]  sel_one;
    logic [4:0]  sel_full;
    logic        tx_one;
    logic        tx_full;
    logic        busy_one;
    logic        busy_full;
    logic        done_one;
    logic        done_full;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor state, index 0 = single-register instance, 1 = full dump
    int          mon_cnt[2]  = '{0, 0};
    logic        mon_in[2]   = '{1'b0, 1'b0};
    logic [7:0]  mon_shift[2];
    logic [4:0]  frame_sel[2];
    logic [7:0]  rx_byte[2][0:599];
    logic [4:0]  rx_sel[2][0:599];
    int          n_rx[2]     = '{0, 0};
    int          n_done[2]   = '{0, 0};
    int          done_cyc[2] = '{0, 0};
    int          mon_err[2]  = '{0, 0};

    assign data_full = {27'd0, sel_full} * 32'h01010101;

    reg_dump_tx #(.CLK_DIV(CD), .NREG(1)) dut_one (
        .clk      (clk),
        .rst      (rst_one),
        .start    (start_one),
        .reg_sel  (sel_one),
        .reg_data (data_one),
        .tx       (tx_one),
        .busy     (busy_one),
        .done     (done_one)
    );

    reg_dump_tx #(.CLK_DIV(CD), .NREG(32)) dut_full (
        .clk      (clk),
        .rst      (rst_full),
        .start    (start_full),
        .reg_sel  (sel_full),
        .reg_data (data_full),
        .tx       (tx_full),
        .busy     (busy_full),
        .done     (done_full)
    );

    // Free-running clock and a count of rising edges seen so far
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Safety net in case some wait is not bounded as intended
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // UART decoder: sample every cycle on the falling edge, require each
    // bit to hold its level for all CD samples, and store completed bytes
    // along with the reg_sel seen when the start bit began.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       t;
            logic       r;
            logic       d;
            logic [4:0] s;
            int         b;
            int         ph;
            t = (i == 0) ? tx_one   : tx_full;
            r = (i == 0) ? rst_one  : rst_full;
            d = (i == 0) ? done_one : done_full;
            s = (i == 0) ? sel_one  : sel_full;
            if (d) begin
                n_done[i]++;
                done_cyc[i] = cyc;
            end
            if (r) begin
                mon_in[i]  = 1'b0;
                mon_cnt[i] = 0;
            end else if (!mon_in[i]) begin
                if (t == 1'b0) begin
                    mon_in[i]    = 1'b1;
                    mon_cnt[i]   = 1;
                    frame_sel[i] = s;
                end
            end else begin
                b  = mon_cnt[i] / CD;
                ph = mon_cnt[i] % CD;
                if (b == 0) begin
                    if (t !== 1'b0) mon_err[i]++;
                end else if (b <= 8) begin
                    if (ph == 0) mon_shift[i][b-1] = t;
                    else if (t !== mon_shift[i][b-1]) mon_err[i]++;
                end else begin
                    if (t !== 1'b1) mon_err[i]++;
                end
                mon_cnt[i]++;
                if (mon_cnt[i] == 10 * CD) begin
                    mon_in[i] = 1'b0;
                    if (n_rx[i] < 600) begin
                        rx_byte[i][n_rx[i]] = mon_shift[i];
                        rx_sel[i][n_rx[i]]  = frame_sel[i];
                    end
                    n_rx[i]++;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [71:0] observed,
                               input logic [71:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic val);
        if (i == 0) start_one = val;
        else        start_full = val;
    endtask

    task automatic waitDone(input int i, input int base, input int budget, input string tag);
        int n;
        n = 0;
        while (n_done[i] == base && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 72'(n_done[i] - base), 72'd1);
    endtask

    function automatic logic [71:0] packBytes(input int i, input int k);
        logic [71:0] v;
        v = '0;
        for (int j = 0; j < 9; j++) begin
            if (k + j < 600) v = {v[63:0], rx_byte[i][k+j]};
            else             v = {v[63:0], 8'h00};
        end
        return v;
    endfunction

    // Independent hex-text model: "XXXXXXXX\n" for a 32-bit value
    function automatic logic [71:0] hexLine(input logic [31:0] val);
        logic [71:0] v;
        logic [3:0]  nib;
        v = '0;
        for (int n = 7; n >= 0; n--) begin
            nib = val[n*4 +: 4];
            if (nib < 4'd10) v = {v[63:0], 8'h30 + 8'(nib)};
            else             v = {v[63:0], 8'h41 + 8'(nib) - 8'd10};
        end
        v = {v[63:0], 8'h0A};
        return v;
    endfunction

    initial begin
        int e0;
        int b_rx;
        int b_done;
        int b_err;
        int sel_bad;
        int n;

        // Asynchronous reset, checked before the first rising edge
        #1;
        rst_one  = 1'b1;
        rst_full = 1'b1;
        #1;
        checkOutput("rst_tx",      72'(tx_full),   72'd1);
        checkOutput("rst_busy",    72'(busy_full), 72'd0);
        checkOutput("rst_done",    72'(done_full), 72'd0);
        checkOutput("rst_reg_sel", 72'(sel_full),  72'd0);
        checkOutput("rst_tx_one",  72'(tx_one),    72'd1);
        repeat (3) @(negedge clk);
        #1;
        rst_one  = 1'b0;
        rst_full = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("idle_tx",      72'(tx_full),   72'd1);
        checkOutput("idle_busy",    72'(busy_full), 72'd0);
        checkOutput("idle_reg_sel", 72'(sel_full),  72'd0);

        // Single register, NREG=1
        data_one = 32'h1234ABCD;
        b_rx   = n_rx[0];
        b_done = n_done[0];
        b_err  = mon_err[0];
        applyStimulus(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        e0 = cyc;
        applyStimulus(0, 1'b0);
        checkOutput("one_busy_after_e0", 72'(busy_one), 72'd1);
        checkOutput("one_sel_after_e0",  72'(sel_one),  72'd0);
        checkOutput("one_tx_after_e0",   72'(tx_one),   72'd1);
        @(negedge clk);
        #1;
        checkOutput("one_start_bit", 72'(tx_one), 72'd0);
        waitDone(0, b_done, 500, "one_done_seen");
        checkOutput("one_done_time",  72'(done_cyc[0] - e0), 72'd361);
        checkOutput("one_busy_fall",  72'(busy_one), 72'd0);
        checkOutput("one_byte_count", 72'(n_rx[0] - b_rx), 72'd9);
        checkOutput("one_bytes", packBytes(0, b_rx), 72'h31_32_33_34_41_42_43_44_0A);
        checkOutput("one_line_err", 72'(mon_err[0] - b_err), 72'd0);

        // Reset in the middle of d3 of byte 2 on the full instance
        b_rx = n_rx[1];
        applyStimulus(1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        e0 = cyc;
        applyStimulus(1, 1'b0);
        n = 0;
        while (cyc < e0 + 99 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        checkOutput("mid_bytes_before_rst", 72'(n_rx[1] - b_rx), 72'd2);
        checkOutput("mid_tx_d3",            72'(tx_full), 72'd0);
        rst_full = 1'b1;
        #1;
        checkOutput("mid_rst_tx",      72'(tx_full),   72'd1);
        checkOutput("mid_rst_busy",    72'(busy_full), 72'd0);
        checkOutput("mid_rst_done",    72'(done_full), 72'd0);
        checkOutput("mid_rst_reg_sel", 72'(sel_full),  72'd0);
        @(negedge clk);
        #1;
        rst_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("post_rst_tx",   72'(tx_full),   72'd1);
        checkOutput("post_rst_busy", 72'(busy_full), 72'd0);

        // Full 32-register dump with a start pulse during register 5
        b_rx   = n_rx[1];
        b_done = n_done[1];
        b_err  = mon_err[1];
        applyStimulus(1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        e0 = cyc;
        applyStimulus(1, 1'b0);
        checkOutput("full_sel_start",  72'(sel_full),  72'd0);
        checkOutput("full_busy_start", 72'(busy_full), 72'd1);
        n = 0;
        while (sel_full != 5'd5 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("full_reached_sel5", 72'(sel_full), 72'd5);
        repeat (20) @(negedge clk);
        #1;
        applyStimulus(1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        applyStimulus(1, 1'b0);
        waitDone(1, b_done, 12000, "full_done_seen");
        checkOutput("full_done_time",  72'(done_cyc[1] - e0), 72'd11552);
        checkOutput("full_byte_count", 72'(n_rx[1] - b_rx), 72'd288);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("full_reg%0d", k), packBytes(1, b_rx + 9 * k),
                        hexLine(32'(k) * 32'h01010101));
        end
        checkOutput("full_reg31_text", packBytes(1, b_rx + 279),
                    72'h31_46_31_46_31_46_31_46_0A);
        sel_bad = 0;
        for (int j = 0; j < 288; j++) begin
            if (b_rx + j < 600 && rx_sel[1][b_rx+j] != 5'(j / 9)) sel_bad++;
        end
        checkOutput("full_sel_sequence", 72'(sel_bad), 72'd0);
        checkOutput("full_line_err", 72'(mon_err[1] - b_err), 72'd0);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("full_done_once", 72'(n_done[1] - b_done), 72'd1);
        checkOutput("full_busy_end",  72'(busy_full), 72'd0);
        checkOutput("full_tx_end",    72'(tx_full),   72'd1);

        // Start held high across two back-to-back dumps
        data_one = 32'h0F9A5E60;
        b_rx   = n_rx[0];
        b_done = n_done[0];
        b_err  = mon_err[0];
        applyStimulus(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        e0 = cyc;
        waitDone(0, b_done, 500, "held_first_done");
        checkOutput("held_done_time", 72'(done_cyc[0] - e0), 72'd361);
        checkOutput("held_busy_low",  72'(busy_one), 72'd0);
        checkOutput("held_tx_gap0",   72'(tx_one),   72'd1);
        @(negedge clk);
        #1;
        checkOutput("held_busy_rise", 72'(busy_one), 72'd1);
        checkOutput("held_done_drop", 72'(done_one), 72'd0);
        checkOutput("held_tx_gap1",   72'(tx_one),   72'd1);
        checkOutput("held_sel_zero",  72'(sel_one),  72'd0);
        applyStimulus(0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("held_second_start_bit", 72'(tx_one), 72'd0);
        data_one = 32'hFFFFFFFF;
        waitDone(0, b_done + 1, 500, "held_second_done");
        checkOutput("held_byte_count", 72'(n_rx[0] - b_rx), 72'd18);
        checkOutput("held_bytes_1", packBytes(0, b_rx),     72'h30_46_39_41_35_45_36_30_0A);
        checkOutput("held_bytes_2", packBytes(0, b_rx + 9), 72'h30_46_39_41_35_45_36_30_0A);
        checkOutput("held_line_err", 72'(mon_err[0] - b_err), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Debug register-dump transmitter for the single-cycle CPU top (`sccomp`). On a start request, it acts as the initiator on the CPU's debug register port: it walks `reg_sel` through registers 0..NREG-1 and samples `reg_data` for each one. Each value goes out on a UART TX line as 8 uppercase hex ASCII characters followed by a newline. This replaces manual `reg_sel` poking from the bench or board switches with a host-readable dump.

## Interface
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- `NREG`, default 32: number of registers dumped, starting at index 0. Legal range 1..32.
- `clk`  in  1: system clock, the same clock as `sccomp`.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: dump request, sampled only in IDLE. Level-sensitive.
- `reg_sel`  out  5: register index driven to `sccomp.reg_sel`, registered.
- `reg_data`  in  32: register value returned by `sccomp.reg_data`, combinational on the `sccomp` side.
- `tx`  out  1: UART serial output. Idles high. Frame is 8N1, LSB first.
- `busy`  out  1: high while a dump is in progress.
- `done`  out  1: one-cycle pulse when the last stop bit of the last register completes.

## Operation
- States:
  - IDLE: if `start`=1, set `reg_sel`=0 and `busy`=1, then go to SEL.
  - SEL: capture `reg_data` into a 32-bit hold register, clear the byte counter to 0, go to SEND.
  - SEND: transmit the current byte.
  - NEXT:
    - If byte counter < 8: increment it, go to SEND.
    - Else if `reg_sel` < NREG-1: increment `reg_sel`, go to SEL.
    - Else: pulse `done`, clear `busy`, go to IDLE.
- Bytes per register (counter 0..8):
  - Counters 0..7 send hold[31:28] first down to hold[3:0] last.
  - Counter 8 sends 0x0A.
- Nibble to ASCII: n ≤ 9 maps to 0x30+n. n ≥ 10 maps to 0x41+(n-10), i.e. uppercase A-F.
- UART frame: start bit 0, then data bits d0..d7, then stop bit 1. Each bit is held exactly CLK_DIV cycles.
- Baud counter:
  - Width is $clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1 and wraps.
  - Bit index 0..9 advances on wrap.
  - Leaving the stop bit goes straight to NEXT. NEXT is merged into the last stop-bit cycle, so there is no idle gap between bytes.
- `reg_sel` stays constant for the whole time one register is being sent.
- `reg_data` is sampled once per register, in SEL. Later changes to it do not affect the bytes in flight.
- `start` while `busy`=1 is ignored: no restart and no queuing.
- If `start` is still high when IDLE is re-entered, a new dump begins on the next edge.
- `reg_sel` is never driven to NREG or above.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `reg_sel`=0, state=IDLE, all counters 0.
- Reset applies immediately (asynchronously), including mid-frame.
- Take E0 as the edge that samples `start`=1 in IDLE.
  - `busy` and `reg_sel`=0 are valid after E0.
  - `reg_data` is captured at E1.
  - `tx` falls for the start bit after E1.
- Per register: 1 SEL cycle + 9 × 10 × CLK_DIV cycles on the line.
- A full dump lasts NREG × (1 + 90 × CLK_DIV) cycles from E0.
- `done` is high for the single cycle immediately after the final stop bit.
- `busy` falls on the same edge that `done` rises.
- `tx`=1 in all cycles outside frames, including the SEL cycle between registers.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle. Required: `tx`=1, `busy`=0, `done`=0 and `reg_sel`=0 before the next clock edge. Release `rst`: outputs stay unchanged with `start`=0.
- **Single register** (CLK_DIV=4, NREG=1, `reg_data`=32'h1234ABCD).
  - Line bytes: 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0A, each bit exactly 4 cycles.
  - `done` pulses 361 cycles after E0.
- **Full dump** (CLK_DIV=4, NREG=32, `reg_data`=`reg_sel`×32'h01010101).
  - `reg_sel` steps 0..31 in order.
  - Register 31 prints "1F1F1F1F\n".
  - Exactly 288 bytes are sent.
  - `done` fires once, 32 × 361 = 11552 cycles after E0.
- **Start while busy.** Pulse `start` during register 5 of a dump. Required: `reg_sel` sequence unaffected, one `done`, byte count unchanged.
- **Reset mid-frame.** Assert `rst` during data bit d3 of byte 2. Required:
  - `tx`=1 and `busy`=0 immediately.
  - A subsequent `start` dumps again from `reg_sel`=0, with a clean start bit.
- **Start held high.** Hold `start`=1 across two dumps. Required: the second dump's `busy` rises on the edge right after `done`, and `tx` stays idle-high between the two dumps.
